// File: rtl/apb_i2c_pkg.sv
// apb_i2c_pkg
// Shared types and defaults for the APB-to-I2C requester.
//   state_t            : requester FSM states (IDLE/REQ/WAIT/DONE)
//   DEF_ADDR_W/DATA_W  : default address/data widths
//   DEF_TIMEOUT_CYCLES : default WAIT timeout (used only with APB_I2C_TIMEOUT_EN)
//   tmo_cnt_w()        : width of the timeout counter for a given cycle count
package apb_i2c_pkg;

  localparam int unsigned DEF_ADDR_W         = 8;
  localparam int unsigned DEF_DATA_W         = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Counter only has to reach cycles-1; never narrower than 1 bit.
  function automatic int unsigned tmo_cnt_w(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/apb_i2c_timeout.sv
// apb_i2c_timeout
// WAIT-state watchdog for apb_i2c_requester (built only with APB_I2C_TIMEOUT_EN).
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clear        : zero the counter (asserted the cycle before WAIT entry)
//   i_enable       : count one WAIT cycle
//   o_expired      : counter has reached TIMEOUT_CYCLES-1 while enabled
module apb_i2c_timeout
  import apb_i2c_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned     CW   = tmo_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/apb_i2c_requester.sv
// apb_i2c_requester
// APB3 completer that turns each APB transfer into a single-cycle request to
// an I2C master and stalls PREADY until the master reports completion.
// Optional WAIT timeout: define APB_I2C_TIMEOUT_EN.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  : APB request
//   PREADY/PRDATA/PSLVERR             : APB completion (all registered)
//   i2c_ce/i2c_wren/i2c_rden          : one-cycle request strobe + direction
//   i2c_addr/i2c_wdata                : request fields, held until next setup
//   i2c_ready/i2c_rdata/i2c_error     : completion pulse and result from master
module apb_i2c_requester
  import apb_i2c_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR,
  output logic              i2c_ce,
  output logic              i2c_wren,
  output logic              i2c_rden,
  output logic [ADDR_W-1:0] i2c_addr,
  output logic [DATA_W-1:0] i2c_wdata,
  input  logic              i2c_ready,
  input  logic [DATA_W-1:0] i2c_rdata,
  input  logic              i2c_error
);

  state_t             r_state;
  logic               r_write;
  logic               r_pready;
  logic               r_pslverr;
  logic [DATA_W-1:0]  r_prdata;
  logic               r_ce;
  logic               r_wren;
  logic               r_rden;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;

  logic w_setup;
  logic w_expired;

  assign w_setup = PSEL && !PENABLE;

`ifdef APB_I2C_TIMEOUT_EN
  logic w_tmo_clear;
  logic w_tmo_enable;

  assign w_tmo_clear  = (r_state == ST_REQ);
  assign w_tmo_enable = (r_state == ST_WAIT);

  apb_i2c_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_clear   (w_tmo_clear),
    .i_enable  (w_tmo_enable),
    .o_expired (w_expired)
  );
`else
  // No watchdog: WAIT holds until i2c_ready. TIMEOUT_CYCLES must be >= 1,
  // so this is a constant 0.
  assign w_expired = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_write   <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      r_ce      <= 1'b0;
      r_wren    <= 1'b0;
      r_rden    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Only a genuine setup phase starts a transfer; a late i2c_ready
          // from an abandoned operation is ignored here.
          if (w_setup) begin
            r_addr  <= PADDR;
            if (PWRITE) begin
              r_wdata <= PWDATA;
            end
            r_write <= PWRITE;
            r_ce    <= 1'b1;
            r_wren  <= PWRITE;
            r_rden  <= !PWRITE;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_ce    <= 1'b0;
          r_wren  <= 1'b0;
          r_rden  <= 1'b0;
          r_state <= PSEL ? ST_WAIT : ST_IDLE;
        end
        ST_WAIT: begin
          // Abort beats completion; completion beats timeout.
          if (!PSEL) begin
            r_state <= ST_IDLE;
          end else if (i2c_ready) begin
            r_pready  <= 1'b1;
            r_prdata  <= r_write ? '0 : i2c_rdata;
            r_pslverr <= i2c_error;
            r_state   <= ST_DONE;
          end else if (w_expired) begin
            r_pready  <= 1'b1;
            r_prdata  <= '0;
            r_pslverr <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_pready  <= 1'b0;
          r_prdata  <= '0;
          r_pslverr <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign PREADY    = r_pready;
  assign PRDATA    = r_prdata;
  assign PSLVERR   = r_pslverr;
  assign i2c_ce    = r_ce;
  assign i2c_wren  = r_wren;
  assign i2c_rden  = r_rden;
  assign i2c_addr  = r_addr;
  assign i2c_wdata = r_wdata;

endmodule

// File: doc/apb_i2c_requester.md
Name: apb_i2c_requester

Overview:
- APB3 completer that initiates transactions on the APB-to-I2C-master request interface (the APB end of that bus).
- Converts one APB transfer into one single-cycle request on ce/wren/rden with held addr/wdata.
- Stalls the APB access phase via PREADY until the I2C master signals ready, then returns rdata/error as PRDATA/PSLVERR.
- Sits between the system APB fabric and the I2C master.

Parameters:
- ADDR_W, 8, width of PADDR and of the addr driven to the I2C master
- DATA_W, 8, width of PWDATA/PRDATA and of the wdata/rdata path
- TIMEOUT_CYCLES, 1024, WAIT-state cycles before forced error completion (only with the optional feature)

Ports:
- clk  input  1  single system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- PSEL  input  1  APB select
- PENABLE  input  1  APB access phase
- PWRITE  input  1  1 = write, 0 = read
- PADDR  input  ADDR_W  APB address
- PWDATA  input  DATA_W  APB write data
- PREADY  output  1  transfer complete
- PRDATA  output  DATA_W  read data
- PSLVERR  output  1  transfer error
- i2c_ce  output  1  request strobe to the I2C master
- i2c_wren  output  1  write request, qualified by i2c_ce
- i2c_rden  output  1  read request, qualified by i2c_ce
- i2c_addr  output  ADDR_W  target register/byte address
- i2c_wdata  output  DATA_W  write data
- i2c_ready  input  1  completion pulse from the I2C master
- i2c_rdata  input  DATA_W  read result, valid with i2c_ready
- i2c_error  input  1  NACK/bus error, valid with i2c_ready

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; timeout counter 0.
  - Reset mid-operation returns everything to reset values at the next edge.
  - The outstanding I2C operation is not cancelled; its late i2c_ready is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On PSEL=1 and PENABLE=0 (setup phase), latch PADDR into i2c_addr, PWDATA into i2c_wdata (write only) and PWRITE internally.
  - Go to REQ.
- REQ, exactly 1 cycle:
  - i2c_ce=1, i2c_wren=PWRITE, i2c_rden=!PWRITE; PREADY=0.
  - Go to WAIT.
- WAIT:
  - ce/wren/rden return to 0; i2c_addr and i2c_wdata held stable; PREADY=0.
  - i2c_ready is sampled only in WAIT; a ready in REQ is ignored.
  - On i2c_ready=1, register PRDATA = i2c_rdata (reads) or 0 (writes), and PSLVERR = i2c_error.
  - Go to DONE.
- DONE, 1 cycle:
  - PREADY=1 with PRDATA/PSLVERR valid.
  - Next cycle PREADY, PRDATA and PSLVERR clear to 0; go to IDLE.
- Latency:
  - Setup at cycle 0, ce at cycle 1.
  - i2c_ready at cycle k gives PREADY at cycle k+1.
  - Minimum transfer length (setup to PREADY) is 4 cycles.
- Back-to-back: a new setup phase is accepted in the cycle after DONE.
- PSEL deasserted in REQ or WAIT (protocol violation):
  - Abort to IDLE next cycle; no PREADY pulse, no re-request.
  - The pending i2c_ready is ignored.
- PSEL held with PENABLE=1 while in IDLE: ignored (no setup seen).
- i2c_addr and i2c_wdata change only on accepted setup phases.

Optional Feature:
- Macro: APB_I2C_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no i2c_ready, go to DONE with PSLVERR=1, PRDATA=0.
  - If i2c_ready arrives in the same cycle as expiry, i2c_ready wins (normal completion).
- Undefined: no counter; WAIT holds indefinitely until i2c_ready or reset.

Decomposition:
- Package apb_i2c_pkg:
  - state enum (IDLE/REQ/WAIT/DONE)
  - default ADDR_W/DATA_W constants
  - default TIMEOUT_CYCLES constant
  - counter width derived via $clog2.
- Sub-module apb_i2c_timeout:
  - clear/enable/expired counter, instantiated only under APB_I2C_TIMEOUT_EN.

Test Plan:
- Write, PADDR=0x3C, PWDATA=0xA5, i2c_ready 5 cycles after ce, i2c_error=0 -> ce/wren high exactly 1 cycle; addr=0x3C and wdata=0xA5 held; PREADY 1 cycle after ready; PSLVERR=0.
- Read, PADDR=0x10, ready with rdata=0x5A, error=0 -> rden 1 cycle; PRDATA=0x5A with PREADY; PRDATA=0 the following cycle.
- Read with i2c_error=1 (NACK) -> PSLVERR=1 with PREADY, PRDATA=0x?? equals rdata sampled; next transfer completes with PSLVERR=0.
- APB_I2C_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ready:
  - PREADY=1, PSLVERR=1 exactly 16 cycles after WAIT entry.
  - Ready coinciding with expiry gives PSLVERR=i2c_error.
- Reset asserted 2 cycles into WAIT, then late i2c_ready -> all outputs 0, no PREADY; next write 0x01/0x77 completes normally.
- Back-to-back write then read with 0-cycle APB gap -> two distinct ce pulses; both transfers complete in order with correct data.
